// File: rtl/rv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv_fetch_pkg
// Shared definitions for the instruction fetch front end.
//   XLEN       : datapath / address width
//   INSTR_NOP  : canonical RV32I NOP (addi x0, x0, 0)
//   PC_INC     : sequential PC increment
//   fetch_entry_t : one buffered fetch result {instr, pc, pc+4}
//   align_pc() : force a PC onto a word boundary
// -----------------------------------------------------------------------------
package rv_fetch_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t INSTR_NOP = 32'h0000_0013;
  localparam word_t PC_INC    = 32'd4;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pcplus4;
  } fetch_entry_t;

  // Low two bits of a redirect target are dropped without raising anything.
  function automatic word_t align_pc(input word_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Parameterised synchronous FIFO. The head entry is read straight out of the
// storage flops, so head_valid/head_data depend on registered state only.
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low reset (empties the FIFO)
//   flush      in   empty the FIFO at this edge; overrides push and pop
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   remove the head entry (ignored when empty)
//   head_valid out  FIFO holds at least one entry
//   head_data  out  oldest entry
//   count      out  number of entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observable
  // through head_valid, which comes from the reset count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Callers size their traffic so a push never lands on a full FIFO.
  assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && !flush && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
// Fetch front end feeding the Fetch-Decode register. Owns the fetch PC, issues
// in-order requests to a variable-latency instruction memory, buffers returned
// words and presents {instr, pc, pc+4}. An Execute-stage redirect flushes the
// queue and arranges for responses of the old stream to be discarded.
//   clk             in   clock, rising edge
//   reset           in   synchronous, active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_addr   out  fetch address (word aligned)
//   imem_req_ready  in   memory accepts the request
//   imem_rsp_valid  in   response word valid (in request order)
//   imem_rsp_data   in   instruction word
//   redirect_valid  in   branch/jump redirect from Execute
//   redirect_pc     in   redirect target
//   stall           in   decode stall, holds the head entry
//   instr_valid     out  head entry valid
//   instr_out       out  head instruction
//   instr_pc        out  head PC
//   instr_pcplus4   out  head PC+4
// -----------------------------------------------------------------------------
module ifetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             instr_valid,
  output logic [XLEN-1:0]  instr_out,
  output logic [XLEN-1:0]  instr_pc,
  output logic [XLEN-1:0]  instr_pcplus4
);

  localparam int CW = $clog2(DEPTH + 1);

  word_t         fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;    // requests accepted, response not yet seen
  logic [CW-1:0] drop_q, drop_d;  // old-stream responses still to discard
  logic          run_q;           // low for the first cycle out of reset

  logic          accept, rsp_fire, rsp_keep, q_pop;
  logic [CW-1:0] out_next;
  logic [CW:0]   in_use;

  logic          tag_valid;
  word_t         tag_pc;
  logic [CW-1:0] tag_count;

  fetch_entry_t  q_push_data, q_head;
  logic          q_valid;
  logic [CW-1:0] q_count;

  // Queue slots already taken plus slots promised to in-flight requests.
  // Dropped requests are counted too, which keeps the cap simple and safe.
  assign in_use         = {1'b0, q_count} + {1'b0, out_q};
  assign imem_req_valid = run_q && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = run_q ? fetch_pc_q : '0;

  always_comb begin
    accept   = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid && tag_valid;
    // A response in the redirect cycle belongs to the old stream.
    rsp_keep = rsp_fire && (drop_q == '0) && !redirect_valid;
    q_pop    = q_valid && !stall && !redirect_valid;
    out_next = out_q + CW'(accept) - CW'(rsp_fire);

    fetch_pc_d = fetch_pc_q;
    out_d      = out_next;
    drop_d     = drop_q;

    if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
    if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Everything still outstanding after this cycle, including a request
    // accepted right now, was fetched from the abandoned path.
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      drop_d     = out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
    end
  end

  // PC of every accepted request, consumed by its response whether the word
  // is kept or dropped, so it is never flushed by a redirect.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (1'b0),
    .push       (accept),
    .push_data  (fetch_pc_q),
    .pop        (rsp_fire),
    .head_valid (tag_valid),
    .head_data  (tag_pc),
    .count      (tag_count)
  );

  assign q_push_data = '{instr: imem_rsp_data, pc: tag_pc, pcplus4: tag_pc + PC_INC};

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (rsp_keep),
    .push_data  (q_push_data),
    .pop        (q_pop),
    .head_valid (q_valid),
    .head_data  (q_head),
    .count      (q_count)
  );

  // Outputs read as zero whenever the head is empty, hiding stale storage.
  assign instr_valid   = q_valid;
  assign instr_out     = q_valid ? q_head.instr   : '0;
  assign instr_pc      = q_valid ? q_head.pc      : '0;
  assign instr_pcplus4 = q_valid ? q_head.pcplus4 : '0;

  assert property (@(posedge clk) disable iff (!reset) tag_count == out_q);

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4)
  );

  // Memory model: accepted requests wait in order until their due cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  int          cyc;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rsp_pct = 100;

  // Stream model: next address expected on the request port and next PC
  // expected to be consumed by decode.
  logic [31:0] exp_fetch;
  logic [31:0] exp_deliver;
  logic [31:0] last_pop_pc;
  int          pops;

  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic apply_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_q.delete();
    exp_fetch   = RESET_PC;
    exp_deliver = RESET_PC;
    cyc         = 0;
    pops        = 0;
  endtask

  // One clock cycle: drive the memory response, check what the DUT offers
  // before the edge, then advance the models.
  task automatic step();
    logic        acc, pop;
    logic [31:0] acc_addr, tgt;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    pop      = instr_valid && !stall && !redirect_valid;
    if (acc) begin
      n_total++;
      if (imem_req_addr !== exp_fetch)
        $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_fetch);
      else n_pass++;
    end
    if (pop) begin
      n_total++;
      if (instr_pc !== exp_deliver)
        $display("FAIL instr_pc: got %h expected %h", instr_pc, exp_deliver);
      else n_pass++;
      n_total++;
      if (instr_pcplus4 !== exp_deliver + 32'd4)
        $display("FAIL instr_pcplus4: got %h expected %h", instr_pcplus4, exp_deliver + 32'd4);
      else n_pass++;
      n_total++;
      if (instr_out !== mem_word(exp_deliver))
        $display("FAIL instr_out: got %h expected %h", instr_out, mem_word(exp_deliver));
      else n_pass++;
    end
    n_total++;
    if (imem_req_valid && mem_q.size() >= DEPTH)
      $display("FAIL outstanding_cap: req_valid=1 with %0d in flight, limit %0d", mem_q.size(), DEPTH);
    else n_pass++;
    @(posedge clk);
    #1;
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (acc) begin
      mem_q.push_back('{addr: acc_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (pop) begin
      last_pop_pc = exp_deliver;
      exp_deliver = exp_deliver + 32'd4;
      pops++;
    end
    if (redirect_valid) begin
      tgt         = {redirect_pc[31:2], 2'b00};
      exp_fetch   = tgt;
      exp_deliver = tgt;
      n_total++;
      if (instr_valid !== 1'b0)
        $display("FAIL redirect_flush: instr_valid got %b expected 0", instr_valid);
      else n_pass++;
      n_total++;
      if (imem_req_addr !== tgt)
        $display("FAIL redirect_addr: got %h expected %h", imem_req_addr, tgt);
      else n_pass++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid);
    else n_pass++;
    n_total++;
    if (imem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h expected 0", imem_req_addr);
    else n_pass++;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b expected 0", instr_valid);
    else n_pass++;
    n_total++;
    if ({instr_out, instr_pc, instr_pcplus4} !== 96'h0)
      $display("FAIL rst_instr_fields: got %h %h %h expected zeros", instr_out, instr_pc, instr_pcplus4);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b expected 1", imem_req_valid);
    else n_pass++;
    n_total++;
    if (imem_req_addr !== RESET_PC) $display("FAIL first_req_addr: got %h expected %h", imem_req_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_stream();
    int p0;
    apply_reset();
    lat_min = 1; lat_max = 1; rsp_pct = 100;
    repeat (4) step();
    p0 = pops;
    repeat (12) step();
    n_total++;
    if (pops - p0 !== 12) $display("FAIL throughput: got %0d pops in 12 cycles expected 12", pops - p0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int p0;
    apply_reset();
    for (int i = 0; i < 20 && pops < 2; i++) step();
    n_total++;
    if (pops !== 2) $display("FAIL stall_setup: got %0d pops expected 2", pops);
    else n_pass++;
    stall = 1'b1;
    repeat (6) step();
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL stall_full_req: got %b expected 0", imem_req_valid);
    else n_pass++;
    n_total++;
    if (instr_pc !== 32'h8) $display("FAIL stall_head_pc: got %h expected 00000008", instr_pc);
    else n_pass++;
    stall = 1'b0;
    p0 = pops;
    repeat (4) step();
    n_total++;
    if (pops - p0 !== 4) $display("FAIL stall_drain: got %0d pops expected 4", pops - p0);
    else n_pass++;
    n_total++;
    if (last_pop_pc !== 32'h14) $display("FAIL stall_drain_last: got %h expected 00000014", last_pop_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    int p0;
    apply_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mem_q.size() < 3; i++) step();
    n_total++;
    if (mem_q.size() !== 3) $display("FAIL inflight_setup: got %0d in flight expected 3", mem_q.size());
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (imem_req_valid !== 1'b1) $display("FAIL inflight_req_valid: got %b expected 1", imem_req_valid);
    else n_pass++;
    p0 = pops;
    for (int i = 0; i < 40 && pops == p0; i++) step();
    n_total++;
    if (pops == p0 || last_pop_pc !== 32'h100)
      $display("FAIL inflight_first_pc: got %h (pops %0d) expected 00000100", last_pop_pc, pops - p0);
    else n_pass++;
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_redirect_collide();
    int p0;
    apply_reset();
    repeat (6) step();
    n_total++;
    if ({imem_req_valid, instr_valid, mem_q.size() > 0} !== 3'b111)
      $display("FAIL collide_setup: got %b expected 111", {imem_req_valid, instr_valid, mem_q.size() > 0});
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = $urandom;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (imem_req_valid !== 1'b1) $display("FAIL collide_req_valid: got %b expected 1", imem_req_valid);
    else n_pass++;
    p0 = pops;
    repeat (10) step();
    n_total++;
    if (pops - p0 < 5) $display("FAIL collide_resume: got %0d pops expected at least 5", pops - p0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int p0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    p0 = pops;
    for (int i = 0; i < 30 && pops < p0 + 2; i++) step();
    n_total++;
    if (pops < p0 + 2 || last_pop_pc !== 32'h0)
      $display("FAIL wrap_pc: got %h (pops %0d) expected 00000000", last_pop_pc, pops - p0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    repeat (8) step();
    n_total++;
    if ({imem_req_valid, instr_valid} !== 2'b01)
      $display("FAIL midrst_full: got %b expected 01", {imem_req_valid, instr_valid});
    else n_pass++;
    reset = 1'b0;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, instr_pcplus4} !== 130'h0)
      $display("FAIL midrst_outputs: got %b %h %b %h %h %h expected zeros",
               imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc, instr_pcplus4);
    else n_pass++;
    reset = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC})
      $display("FAIL midrst_restart: got %b %h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
    mem_q.delete();
    exp_fetch   = RESET_PC;
    exp_deliver = RESET_PC;
    pops        = 0;
    repeat (8) step();
    n_total++;
    if (pops < 4) $display("FAIL midrst_resume: got %0d pops expected at least 4", pops);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    lat_min = 1; lat_max = 4; rsp_pct = 80;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(99) < 80);
      stall          = ($urandom_range(99) < 30);
      redirect_valid = ($urandom_range(99) < 5);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    rsp_pct        = 100;
    repeat (20) step();
    n_total++;
    if (pops < 50) $display("FAIL random_progress: got %0d pops expected at least 50", pops);
    else n_pass++;
    lat_min = 1; lat_max = 1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
